// File: rtl/decode_queue_unit_pkg.sv
// Shared definitions for the Core101 decode stage.
// Holds the opcode constants (ins[6:2]), the one-hot execution-unit select
// codes, the uop codes, the decoder FSM state type and the packed layout
// of a decoded entry (everything except the PC) as it sits in the FIFO.
package core101_dec_pkg;

  // Major opcodes, taken from ins[6:2]
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_OPV    = 5'b10101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // One-hot execution-unit selects
  localparam logic [2:0] EXEC_INT = 3'b001;
  localparam logic [2:0] EXEC_LSU = 3'b010;
  localparam logic [2:0] EXEC_VEC = 3'b100;

  // ALU uops (OP / OPIMM)
  localparam logic [3:0] UOP_ADD  = 4'b0000;
  localparam logic [3:0] UOP_SUB  = 4'b0001;
  localparam logic [3:0] UOP_OR   = 4'b0010;
  localparam logic [3:0] UOP_AND  = 4'b0011;
  localparam logic [3:0] UOP_XOR  = 4'b0100;
  localparam logic [3:0] UOP_SLT  = 4'b1010;
  localparam logic [3:0] UOP_SLTU = 4'b1011;
  localparam logic [3:0] UOP_SRA  = 4'b1101;
  localparam logic [3:0] UOP_SRL  = 4'b1110;
  localparam logic [3:0] UOP_SLL  = 4'b1111;

  // Load / store uops
  localparam logic [3:0] UOP_LB  = 4'b0001;
  localparam logic [3:0] UOP_LH  = 4'b0010;
  localparam logic [3:0] UOP_LW  = 4'b0011;
  localparam logic [3:0] UOP_LBU = 4'b0101;
  localparam logic [3:0] UOP_LHU = 4'b0110;
  localparam logic [3:0] UOP_SB  = 4'b1001;
  localparam logic [3:0] UOP_SH  = 4'b1010;
  localparam logic [3:0] UOP_SW  = 4'b1100;

  localparam logic [3:0] UOP_LUI = 4'b1001;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_EXC = 1'b1
  } dec_state_t;

  typedef struct packed {
    logic [2:0] exec_sel;
    logic [3:0] uop;
    logic       pc_mux_sel;
    logic       imm_mux_sel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } dec_fields_t;

  localparam int DEC_FIELDS_W = $bits(dec_fields_t);

  // funct3 -> ALU uop; alt picks SUB over ADD and SRA over SRL.
  function automatic logic [3:0] alu_uop(input logic [2:0] funct3, input logic alt);
    logic [3:0] u;
    case (funct3)
      3'b000:  u = alt ? UOP_SUB : UOP_ADD;
      3'b001:  u = UOP_SLL;
      3'b010:  u = UOP_SLT;
      3'b011:  u = UOP_SLTU;
      3'b100:  u = UOP_XOR;
      3'b101:  u = alt ? UOP_SRA : UOP_SRL;
      3'b110:  u = UOP_OR;
      default: u = UOP_AND;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/decode_queue_unit_fifo.sv
// dec_fifo: synchronous FIFO of WIDTH-bit entries, DEPTH slots (power of two).
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   clr             synchronous clear (drops every entry)
//   push, push_data write one entry; ignored when full
//   pop             drop the head entry; ignored when empty
//   full, empty     status
//   head_data       entry at the head (meaningless when empty)
//   count           number of stored entries, 0..DEPTH
module dec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [PTR_W-1:0] rd_ptr_p1;
  logic [PTR_W:0]   cnt_p1;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Control: pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      cnt_p1    <= '0;
    end else begin
      if (do_push) wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
      if (do_pop)  rd_ptr_p1 <= rd_ptr_p1 + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_p1 <= cnt_p1 + (PTR_W+1)'(1);
        2'b01:   cnt_p1 <= cnt_p1 - (PTR_W+1)'(1);
        default: cnt_p1 <= cnt_p1;
      endcase
    end
  end

  // Storage: data only, never reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_p1] <= push_data;
  end

  assign full      = (cnt_p1 == (PTR_W+1)'(DEPTH));
  assign empty     = (cnt_p1 == '0);
  assign head_data = mem[rd_ptr_p1];
  assign count     = cnt_p1;

endmodule

// File: rtl/decode_queue_unit.sv
// decode_queue_unit: Core101 decode stage between fetch and issue.
// Decodes raw 32-bit instructions (valid/ready in), queues legal ones in a
// DEPTH-entry FIFO (valid/ready out) and turns an illegal encoding into a
// held exception that stalls intake until exception_ack_in.
// Ports:
//   clock_in, reset_in                 clock, synchronous active-high reset
//   ins_in, pc_in, ins_valid_in,
//   ins_ready_out                      instruction intake
//   flush_in                           drop queue and pending exception
//   dec_valid_out, dec_ready_in        head handshake
//   dec_exec_unit_sel_out, dec_uop_out, dec_pc_mux_sel_out,
//   dec_imm_mux_sel_out, dec_rs1_out, dec_rs2_out, dec_rd_out,
//   dec_pc_out                         decoded head entry
//   exception_out, exception_pc_out,
//   exception_ack_in                   illegal-instruction exception
//   occupancy_out                      FIFO entry count
// Optional (macro CORE101_DEC_PERF_CNT_EN): perf_int_cnt_out,
//   perf_lsu_cnt_out, perf_vec_cnt_out, saturating per-unit push counters.
module decode_queue_unit
  import core101_dec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic [31:0]              ins_in,
  input  logic [XLEN-1:0]          pc_in,
  input  logic                     ins_valid_in,
  output logic                     ins_ready_out,
  input  logic                     flush_in,
  output logic                     dec_valid_out,
  input  logic                     dec_ready_in,
  output logic [2:0]               dec_exec_unit_sel_out,
  output logic [3:0]               dec_uop_out,
  output logic                     dec_pc_mux_sel_out,
  output logic                     dec_imm_mux_sel_out,
  output logic [4:0]               dec_rs1_out,
  output logic [4:0]               dec_rs2_out,
  output logic [4:0]               dec_rd_out,
  output logic [XLEN-1:0]          dec_pc_out,
  output logic                     exception_out,
  output logic [XLEN-1:0]          exception_pc_out,
  input  logic                     exception_ack_in,
`ifdef CORE101_DEC_PERF_CNT_EN
  output logic [CNT_W-1:0]         perf_int_cnt_out,
  output logic [CNT_W-1:0]         perf_lsu_cnt_out,
  output logic [CNT_W-1:0]         perf_vec_cnt_out,
`endif
  output logic [$clog2(DEPTH):0]   occupancy_out
);

  localparam int ENTRY_W = XLEN + DEC_FIELDS_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_params
    $error("decode_queue_unit: DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  logic [4:0]       opc_p0;
  logic [2:0]       f3_p0;
  logic [6:0]       f7_p0;
  dec_fields_t      fields_p0;
  logic             legal_p0;
  logic             accept_p0;
  logic             push_p0;
  logic             pop_p0;
  logic             trap_p0;
  dec_state_t       state_p1;
  dec_state_t       state_nxt;
  logic [XLEN-1:0]  exc_pc_p1;
  logic             fifo_full_p1;
  logic             fifo_empty_p1;
  logic [ENTRY_W-1:0] head_p1;
  dec_fields_t      head_fields_p1;
  logic             unused_ins_low;

  // The two low instruction bits carry no information for this decoder.
  assign unused_ins_low = &{1'b0, ins_in[1:0]};

  // ---- Stage p0: combinational decode of ins_in ----
  assign opc_p0 = ins_in[6:2];
  assign f3_p0  = ins_in[14:12];
  assign f7_p0  = ins_in[31:25];

  always_comb begin
    fields_p0             = '0;
    fields_p0.exec_sel    = EXEC_INT;
    fields_p0.uop         = UOP_ADD;
    fields_p0.rs1         = ins_in[19:15];
    fields_p0.rs2         = ins_in[24:20];
    fields_p0.rd          = ins_in[11:7];
    legal_p0              = 1'b1;
    case (opc_p0)
      OPC_LOAD: begin
        fields_p0.exec_sel    = EXEC_LSU;
        fields_p0.imm_mux_sel = 1'b1;
        case (f3_p0)
          3'b000:  fields_p0.uop = UOP_LB;
          3'b001:  fields_p0.uop = UOP_LH;
          3'b010:  fields_p0.uop = UOP_LW;
          3'b100:  fields_p0.uop = UOP_LBU;
          3'b101:  fields_p0.uop = UOP_LHU;
          default: legal_p0 = 1'b0;
        endcase
      end
      OPC_STORE: begin
        fields_p0.exec_sel    = EXEC_LSU;
        fields_p0.imm_mux_sel = 1'b1;
        case (f3_p0)
          3'b000:  fields_p0.uop = UOP_SB;
          3'b001:  fields_p0.uop = UOP_SH;
          3'b010:  fields_p0.uop = UOP_SW;
          default: legal_p0 = 1'b0;
        endcase
      end
      OPC_OP: begin
        if (f7_p0 == F7_BASE)
          fields_p0.uop = alu_uop(f3_p0, 1'b0);
        else if (f7_p0 == F7_ALT && (f3_p0 == 3'b000 || f3_p0 == 3'b101))
          fields_p0.uop = alu_uop(f3_p0, 1'b1);
        else
          legal_p0 = 1'b0;
      end
      OPC_OPIMM: begin
        // funct7 only matters for the shift-immediate forms
        fields_p0.imm_mux_sel = 1'b1;
        fields_p0.uop = alu_uop(f3_p0, (f3_p0 == 3'b101) && (f7_p0 == F7_ALT));
        if (f3_p0 == 3'b001 && f7_p0 != F7_BASE)
          legal_p0 = 1'b0;
        if (f3_p0 == 3'b101 && f7_p0 != F7_BASE && f7_p0 != F7_ALT)
          legal_p0 = 1'b0;
      end
      OPC_BRANCH: begin
        fields_p0.pc_mux_sel = 1'b1;
        fields_p0.uop        = {1'b0, f3_p0};
        if (f3_p0 == 3'b010 || f3_p0 == 3'b011)
          legal_p0 = 1'b0;
      end
      OPC_LUI: begin
        fields_p0.imm_mux_sel = 1'b1;
        fields_p0.uop         = UOP_LUI;
      end
      OPC_AUIPC, OPC_JAL, OPC_JALR: begin
        fields_p0.pc_mux_sel  = 1'b1;
        fields_p0.imm_mux_sel = 1'b1;
      end
      OPC_OPV:    fields_p0.exec_sel = EXEC_VEC;
      OPC_SYSTEM: fields_p0.uop = UOP_ADD;
      default:    legal_p0 = 1'b0;
    endcase
  end

  assign accept_p0 = ins_valid_in && ins_ready_out;
  assign push_p0   = accept_p0 && legal_p0 && !flush_in;
  assign trap_p0   = accept_p0 && !legal_p0;
  assign pop_p0    = dec_valid_out && dec_ready_in;

  // ---- Stage p1: FSM, exception PC and decoded-entry queue ----
  always_ff @(posedge clock_in) begin
    if (reset_in) state_p1 <= ST_RUN;
    else          state_p1 <= state_nxt;
  end

  // Flush wins over both a trapping accept and an acknowledge.
  always_comb begin
    state_nxt = state_p1;
    if (flush_in) begin
      state_nxt = ST_RUN;
    end else begin
      case (state_p1)
        ST_RUN:  if (trap_p0) state_nxt = ST_EXC;
        ST_EXC:  if (exception_ack_in) state_nxt = ST_RUN;
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    ins_ready_out = (state_p1 == ST_RUN) && !fifo_full_p1;
    exception_out = (state_p1 == ST_EXC);
  end

  always_ff @(posedge clock_in) begin
    if (reset_in)                 exc_pc_p1 <= '0;
    else if (trap_p0 && !flush_in) exc_pc_p1 <= pc_in;
  end

  assign exception_pc_out = exc_pc_p1;

  dec_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clock_in),
    .rst       (reset_in),
    .clr       (flush_in),
    .push      (push_p0),
    .push_data ({pc_in, fields_p0}),
    .pop       (pop_p0),
    .full      (fifo_full_p1),
    .empty     (fifo_empty_p1),
    .head_data (head_p1),
    .count     (occupancy_out)
  );

  assign {dec_pc_out, head_fields_p1} = head_p1;
  assign dec_valid_out         = !fifo_empty_p1;
  assign dec_exec_unit_sel_out = head_fields_p1.exec_sel;
  assign dec_uop_out           = head_fields_p1.uop;
  assign dec_pc_mux_sel_out    = head_fields_p1.pc_mux_sel;
  assign dec_imm_mux_sel_out   = head_fields_p1.imm_mux_sel;
  assign dec_rs1_out           = head_fields_p1.rs1;
  assign dec_rs2_out           = head_fields_p1.rs2;
  assign dec_rd_out            = head_fields_p1.rd;

`ifdef CORE101_DEC_PERF_CNT_EN
  logic [CNT_W-1:0] perf_int_p1;
  logic [CNT_W-1:0] perf_lsu_p1;
  logic [CNT_W-1:0] perf_vec_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      perf_int_p1 <= '0;
      perf_lsu_p1 <= '0;
      perf_vec_p1 <= '0;
    end else if (push_p0) begin
      if (fields_p0.exec_sel == EXEC_INT) perf_int_p1 <= sat_inc(perf_int_p1);
      if (fields_p0.exec_sel == EXEC_LSU) perf_lsu_p1 <= sat_inc(perf_lsu_p1);
      if (fields_p0.exec_sel == EXEC_VEC) perf_vec_p1 <= sat_inc(perf_vec_p1);
    end
  end

  assign perf_int_cnt_out = perf_int_p1;
  assign perf_lsu_cnt_out = perf_lsu_p1;
  assign perf_vec_cnt_out = perf_vec_p1;
`endif

endmodule

// File: tb/tb_decode_queue_unit.sv
// Testbench for decode_queue_unit: table-driven decode vectors, directed
// multi-cycle sequences (full queue, exception, flush, reset) and a
// randomized run checked against a queue-based reference model.
module tb_decode_queue_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int NV    = 20;

  logic             clock_in = 1'b0;
  logic             reset_in;
  logic [31:0]      ins_in;
  logic [XLEN-1:0]  pc_in;
  logic             ins_valid_in;
  logic             ins_ready_out;
  logic             flush_in;
  logic             dec_valid_out;
  logic             dec_ready_in;
  logic [2:0]       dec_exec_unit_sel_out;
  logic [3:0]       dec_uop_out;
  logic             dec_pc_mux_sel_out;
  logic             dec_imm_mux_sel_out;
  logic [4:0]       dec_rs1_out;
  logic [4:0]       dec_rs2_out;
  logic [4:0]       dec_rd_out;
  logic [XLEN-1:0]  dec_pc_out;
  logic             exception_out;
  logic [XLEN-1:0]  exception_pc_out;
  logic             exception_ack_in;
  logic [OCC_W-1:0] occupancy_out;
`ifdef CORE101_DEC_PERF_CNT_EN
  logic [CNT_W-1:0] perf_int_cnt_out;
  logic [CNT_W-1:0] perf_lsu_cnt_out;
  logic [CNT_W-1:0] perf_vec_cnt_out;
`endif

  decode_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock_in              (clock_in),
    .reset_in              (reset_in),
    .ins_in                (ins_in),
    .pc_in                 (pc_in),
    .ins_valid_in          (ins_valid_in),
    .ins_ready_out         (ins_ready_out),
    .flush_in              (flush_in),
    .dec_valid_out         (dec_valid_out),
    .dec_ready_in          (dec_ready_in),
    .dec_exec_unit_sel_out (dec_exec_unit_sel_out),
    .dec_uop_out           (dec_uop_out),
    .dec_pc_mux_sel_out    (dec_pc_mux_sel_out),
    .dec_imm_mux_sel_out   (dec_imm_mux_sel_out),
    .dec_rs1_out           (dec_rs1_out),
    .dec_rs2_out           (dec_rs2_out),
    .dec_rd_out            (dec_rd_out),
    .dec_pc_out            (dec_pc_out),
    .exception_out         (exception_out),
    .exception_pc_out      (exception_pc_out),
    .exception_ack_in      (exception_ack_in),
`ifdef CORE101_DEC_PERF_CNT_EN
    .perf_int_cnt_out      (perf_int_cnt_out),
    .perf_lsu_cnt_out      (perf_lsu_cnt_out),
    .perf_vec_cnt_out      (perf_vec_cnt_out),
`endif
    .occupancy_out         (occupancy_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    bit [31:0] ins;
    bit        legal;
    bit [2:0]  sel;
    bit [3:0]  uop;
    bit        pcm;
    bit        imm;
  } vec_t;

  typedef struct packed {
    bit       legal;
    bit [2:0] sel;
    bit [3:0] uop;
    bit       pcm;
    bit       imm;
  } ref_t;

  typedef struct packed {
    bit [31:0] ins;
    bit [31:0] pc;
  } ent_t;

  vec_t tab [NV];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference decoder built from the instruction-set rules.
  function automatic ref_t ref_decode(input bit [31:0] ins);
    ref_t     r;
    bit [2:0] f3;
    bit [6:0] f7;
    bit [3:0] alu [8];
    alu = '{4'b0000, 4'b1111, 4'b1010, 4'b1011, 4'b0100, 4'b1110, 4'b0010, 4'b0011};
    f3 = ins[14:12];
    f7 = ins[31:25];
    r = '0;
    r.legal = 1'b1;
    r.sel = 3'b001;
    case (ins[6:2])
      5'b01100: begin
        if (f7 == 7'd0) r.uop = alu[f3];
        else if (f7 == 7'b0100000 && f3 == 3'd0) r.uop = 4'b0001;
        else if (f7 == 7'b0100000 && f3 == 3'd5) r.uop = 4'b1101;
        else r.legal = 1'b0;
      end
      5'b00100: begin
        r.imm = 1'b1;
        r.uop = alu[f3];
        if (f3 == 3'd1 && f7 != 7'd0) r.legal = 1'b0;
        if (f3 == 3'd5) begin
          if (f7 == 7'b0100000) r.uop = 4'b1101;
          else if (f7 != 7'd0) r.legal = 1'b0;
        end
      end
      5'b00000: begin
        r.sel = 3'b010; r.imm = 1'b1;
        case (f3)
          3'd0: r.uop = 4'b0001;
          3'd1: r.uop = 4'b0010;
          3'd2: r.uop = 4'b0011;
          3'd4: r.uop = 4'b0101;
          3'd5: r.uop = 4'b0110;
          default: r.legal = 1'b0;
        endcase
      end
      5'b01000: begin
        r.sel = 3'b010; r.imm = 1'b1;
        case (f3)
          3'd0: r.uop = 4'b1001;
          3'd1: r.uop = 4'b1010;
          3'd2: r.uop = 4'b1100;
          default: r.legal = 1'b0;
        endcase
      end
      5'b11000: begin
        r.pcm = 1'b1;
        r.uop = {1'b0, f3};
        if (f3 == 3'd2 || f3 == 3'd3) r.legal = 1'b0;
      end
      5'b01101: begin r.imm = 1'b1; r.uop = 4'b1001; end
      5'b00101, 5'b11011, 5'b11001: begin r.pcm = 1'b1; r.imm = 1'b1; end
      5'b10101: r.sel = 3'b100;
      5'b11100: r.uop = 4'b0000;
      default:  r.legal = 1'b0;
    endcase
    return r;
  endfunction

  task automatic push_one(input bit [31:0] ins, input bit [31:0] pc);
    ins_in = ins;
    pc_in = pc;
    ins_valid_in = 1'b1;
    step();
    ins_valid_in = 1'b0;
  endtask

  initial begin
    ent_t     q[$];
    bit       m_exc;
    bit [31:0] m_exc_pc;
    bit       m_ready;
    bit       acc;
    bit       pop;
    ref_t     r;
    bit [31:0] rnd;
    bit [4:0] opc_list [11];

    opc_list = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100, 5'b01101,
                 5'b10101, 5'b11000, 5'b11001, 5'b11011, 5'b11100};

    tab[0]  = '{32'h00208033, 1'b1, 3'b001, 4'b0000, 1'b0, 1'b0};
    tab[1]  = '{32'h40208033, 1'b1, 3'b001, 4'b0001, 1'b0, 1'b0};
    tab[2]  = '{32'h0000A003, 1'b1, 3'b010, 4'b0011, 1'b0, 1'b1};
    tab[3]  = '{32'h00002023, 1'b1, 3'b010, 4'b1100, 1'b0, 1'b1};
    tab[4]  = '{32'h00000063, 1'b1, 3'b001, 4'b0000, 1'b1, 1'b0};
    tab[5]  = '{32'h0000307F, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0};
    tab[6]  = '{32'h40209033, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0};
    tab[7]  = '{32'h4020D013, 1'b1, 3'b001, 4'b1101, 1'b0, 1'b1};
    tab[8]  = '{32'h02001013, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0};
    tab[9]  = '{32'h000010B7, 1'b1, 3'b001, 4'b1001, 1'b0, 1'b1};
    tab[10] = '{32'h00000017, 1'b1, 3'b001, 4'b0000, 1'b1, 1'b1};
    tab[11] = '{32'h0000006F, 1'b1, 3'b001, 4'b0000, 1'b1, 1'b1};
    tab[12] = '{32'h00003003, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0};
    tab[13] = '{32'h00003023, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0};
    tab[14] = '{32'h00002063, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0};
    tab[15] = '{32'h00000057, 1'b1, 3'b100, 4'b0000, 1'b0, 1'b0};
    tab[16] = '{32'h00004063, 1'b1, 3'b001, 4'b0100, 1'b1, 1'b0};
    tab[17] = '{32'h00004003, 1'b1, 3'b010, 4'b0101, 1'b0, 1'b1};
    tab[18] = '{32'h00000073, 1'b1, 3'b001, 4'b0000, 1'b0, 1'b0};
    tab[19] = '{32'h0040D093, 1'b1, 3'b001, 4'b1110, 1'b0, 1'b1};

    reset_in = 1'b1;
    ins_in = '0;
    pc_in = '0;
    ins_valid_in = 1'b0;
    flush_in = 1'b0;
    dec_ready_in = 1'b0;
    exception_ack_in = 1'b0;
    step();
    step();
    reset_in = 1'b0;
    step();

    chk("rst_dec_valid", dec_valid_out, 0);
    chk("rst_occ", occupancy_out, 0);
    chk("rst_exc", exception_out, 0);
    chk("rst_exc_pc", exception_pc_out, 0);
    chk("rst_ready", ins_ready_out, 1);

    // Table: one instruction at a time
    for (int i = 0; i < NV; i++) begin
      dec_ready_in = 1'b0;
      push_one(tab[i].ins, 32'h1000 + 32'(i) * 4);
      if (tab[i].legal) begin
        chk($sformatf("tab%0d_valid", i), dec_valid_out, 1);
        chk($sformatf("tab%0d_occ", i), occupancy_out, 1);
        chk($sformatf("tab%0d_sel", i), dec_exec_unit_sel_out, tab[i].sel);
        chk($sformatf("tab%0d_uop", i), dec_uop_out, tab[i].uop);
        chk($sformatf("tab%0d_pcm", i), dec_pc_mux_sel_out, tab[i].pcm);
        chk($sformatf("tab%0d_imm", i), dec_imm_mux_sel_out, tab[i].imm);
        chk($sformatf("tab%0d_regs", i), {dec_rs1_out, dec_rs2_out, dec_rd_out},
            {tab[i].ins[19:15], tab[i].ins[24:20], tab[i].ins[11:7]});
        chk($sformatf("tab%0d_pc", i), dec_pc_out, 32'h1000 + 32'(i) * 4);
        dec_ready_in = 1'b1;
        step();
        dec_ready_in = 1'b0;
        chk($sformatf("tab%0d_popped", i), occupancy_out, 0);
      end else begin
        chk($sformatf("tab%0d_exc", i), exception_out, 1);
        chk($sformatf("tab%0d_exc_pc", i), exception_pc_out, 32'h1000 + 32'(i) * 4);
        chk($sformatf("tab%0d_ready", i), ins_ready_out, 0);
        chk($sformatf("tab%0d_nopush", i), dec_valid_out, 0);
        exception_ack_in = 1'b1;
        step();
        exception_ack_in = 1'b0;
        chk($sformatf("tab%0d_ack_exc", i), exception_out, 0);
        chk($sformatf("tab%0d_ack_ready", i), ins_ready_out, 1);
      end
    end

    // Fill to DEPTH, attempt one more, then drain in order
    for (int k = 0; k < DEPTH; k++)
      push_one(32'h00208033 | (32'(k) << 7), 32'h300 + 32'(k) * 4);
    chk("full_occ", occupancy_out, DEPTH);
    chk("full_ready", ins_ready_out, 0);
    push_one(32'h00208033, 32'h3F0);
    chk("full_blocked", occupancy_out, DEPTH);
    dec_ready_in = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("drain%0d_pc", k), dec_pc_out, 32'h300 + 32'(k) * 4);
      chk($sformatf("drain%0d_rd", k), dec_rd_out, k);
      step();
    end
    dec_ready_in = 1'b0;
    chk("drain_occ", occupancy_out, 0);
    chk("drain_valid", dec_valid_out, 0);

    // Exception behind queued entries
    push_one(32'h00208033, 32'h180);
    push_one(32'h00208033, 32'h184);
    push_one(32'h0000307F, 32'h200);
    chk("exq_exc", exception_out, 1);
    chk("exq_pc", exception_pc_out, 32'h200);
    chk("exq_ready", ins_ready_out, 0);
    chk("exq_occ", occupancy_out, 2);
    dec_ready_in = 1'b1;
    chk("exq_head0", dec_pc_out, 32'h180);
    step();
    chk("exq_head1", dec_pc_out, 32'h184);
    step();
    dec_ready_in = 1'b0;
    chk("exq_drained", occupancy_out, 0);
    chk("exq_held", exception_out, 1);
    exception_ack_in = 1'b1;
    step();
    exception_ack_in = 1'b0;
    chk("exq_ack_exc", exception_out, 0);
    chk("exq_ack_ready", ins_ready_out, 1);

    // Flush with occupancy 3, a same-cycle push and an ack
    for (int k = 0; k < 3; k++) push_one(32'h00208033, 32'h400 + 32'(k) * 4);
    chk("fl_occ3", occupancy_out, 3);
    flush_in = 1'b1;
    ins_in = 32'h00208033;
    pc_in = 32'h4F0;
    ins_valid_in = 1'b1;
    exception_ack_in = 1'b1;
    #1;
    chk("fl_ready_same_cycle", ins_ready_out, 1);
    step();
    flush_in = 1'b0;
    ins_valid_in = 1'b0;
    exception_ack_in = 1'b0;
    chk("fl_occ", occupancy_out, 0);
    chk("fl_valid", dec_valid_out, 0);
    chk("fl_exc", exception_out, 0);
    step();
    chk("fl_no_late_push", occupancy_out, 0);

    // Flush clears a pending exception
    push_one(32'h02001013, 32'h500);
    chk("flx_exc", exception_out, 1);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    chk("flx_cleared", exception_out, 0);
    chk("flx_ready", ins_ready_out, 1);

    // Reset mid-operation
    push_one(32'h0000A003, 32'h600);
    push_one(32'h00000057, 32'h604);
    push_one(32'h0000307F, 32'h608);
    chk("mr_occ", occupancy_out, 2);
    chk("mr_exc", exception_out, 1);
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    chk("mr_valid", dec_valid_out, 0);
    chk("mr_occ0", occupancy_out, 0);
    chk("mr_exc0", exception_out, 0);
    chk("mr_exc_pc0", exception_pc_out, 0);
    chk("mr_ready", ins_ready_out, 1);
`ifdef CORE101_DEC_PERF_CNT_EN
    chk("mr_perf_int", perf_int_cnt_out, 0);
    chk("mr_perf_lsu", perf_lsu_cnt_out, 0);
    chk("mr_perf_vec", perf_vec_cnt_out, 0);
`endif

    // Randomized run against the reference model
    q.delete();
    m_exc = 1'b0;
    m_exc_pc = '0;
    for (int c = 0; c < 600; c++) begin
      m_ready = !m_exc && (q.size() < DEPTH);
      chk("rnd_ready", ins_ready_out, m_ready);
      chk("rnd_valid", dec_valid_out, q.size() > 0);
      chk("rnd_occ", occupancy_out, q.size());
      chk("rnd_exc", exception_out, m_exc);
      if (m_exc) chk("rnd_exc_pc", exception_pc_out, m_exc_pc);
      if (q.size() > 0) begin
        r = ref_decode(q[0].ins);
        chk("rnd_head",
            {dec_exec_unit_sel_out, dec_uop_out, dec_pc_mux_sel_out, dec_imm_mux_sel_out,
             dec_rs1_out, dec_rs2_out, dec_rd_out, dec_pc_out},
            {r.sel, r.uop, r.pcm, r.imm, q[0].ins[19:15], q[0].ins[24:20],
             q[0].ins[11:7], q[0].pc});
      end

      rnd = $urandom;
      case ($urandom_range(0, 3))
        0:       ins_in = $urandom;
        3:       ins_in = {rnd[31:7], opc_list[$urandom_range(0, 10)], 2'b11};
        default: ins_in = tab[$urandom_range(0, NV - 1)].ins ^ (rnd & 32'h01FF8F80);
      endcase
      pc_in = $urandom;
      ins_valid_in = ($urandom_range(0, 3) != 0);
      dec_ready_in = ($urandom_range(0, 2) != 0);
      exception_ack_in = ($urandom_range(0, 3) == 0);
      flush_in = ($urandom_range(0, 39) == 0);

      acc = ins_valid_in && m_ready;
      pop = (q.size() > 0) && dec_ready_in;
      if (flush_in) begin
        q.delete();
        m_exc = 1'b0;
      end else begin
        if (pop) void'(q.pop_front());
        if (m_exc) begin
          if (exception_ack_in) m_exc = 1'b0;
        end else if (acc) begin
          r = ref_decode(ins_in);
          if (r.legal) q.push_back('{ins: ins_in, pc: pc_in});
          else begin
            m_exc = 1'b1;
            m_exc_pc = pc_in;
          end
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
